fetch_stage: RTL and testbench

//  IF stage of the pipelined MIPS core: holds PC, selects next PC, reads instruction memory and loads the IF/ID register.
//  The ID stage decodes id_instr; its imm16 field feeds the immediate extender.

---
 rtl/fetch_stage_pkg.sv | 44 ++++
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage_pc_reg.sv | 77 +++++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//  Shared constants, types and helpers for the IF stage of the MIPS core.
//  Holds the reset PC, exception vector, legal instruction-memory window,
//  ExcCode values, the NOP encoding, the next-PC select encoding and the
//  packed IF/ID register layout. The fetch-address legality check lives
//  here so every user applies the same AdEL rule.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFC;
    localparam logic [31:0] PC_STEP    = 32'h0000_0004;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        PC_SEL_RESET    = 3'd0,
        PC_SEL_EXC      = 3'd1,
        PC_SEL_ERET     = 3'd2,
        PC_SEL_HOLD     = 3'd3,
        PC_SEL_REDIRECT = 3'd4,
        PC_SEL_SEQ      = 3'd5
    } pc_sel_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exccode;
        logic        valid;
    } ifid_t;

    // A fetch is legal when word aligned and inside the instruction window.
    function automatic logic fetch_addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= IMEM_BASE) && (addr <= IMEM_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//  Instruction-memory bus between the fetch stage and instruction memory.
//  The read is combinational: imem_rdata is valid in the same cycle that
//  imem_addr is presented.
//  Signals:
//   imem_addr   32  fetch address (driven by the fetch stage)
//   imem_rdata  32  instruction word at imem_addr (driven by memory)
//  Modports:
//   master  fetch stage side
//   slave   memory side
interface fetch_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// fetch_pc_reg
//  Program counter register plus the next-PC priority mux of the IF stage.
//  Priority on each rising edge:
//   reset > exc_req > eret_req > stall > redirect > pc+4
//  Ports:
//   clk          in   1   clock
//   reset        in   1   synchronous active-high reset
//   stall        in   1   hold PC
//   redirect     in   1   taken branch/jump resolved in ID
//   redirect_pc  in   32  branch/jump target
//   exc_req      in   1   exception/interrupt entry
//   eret_req     in   1   eret return
//   epc          in   32  eret return target
//   pc           out  32  current PC (registered)
module fetch_pc_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc
);

    pc_sel_e     pc_sel_s;
    logic [31:0] next_pc_s;
    logic [31:0] pc_r;

    // Resolve which source drives the next PC; a redirect during stall is
    // deliberately dropped because ID re-asserts it after the stall.
    always_comb begin
        pc_sel_s = PC_SEL_SEQ;
        if (reset) begin
            pc_sel_s = PC_SEL_RESET;
        end else if (exc_req) begin
            pc_sel_s = PC_SEL_EXC;
        end else if (eret_req) begin
            pc_sel_s = PC_SEL_ERET;
        end else if (stall) begin
            pc_sel_s = PC_SEL_HOLD;
        end else if (redirect) begin
            pc_sel_s = PC_SEL_REDIRECT;
        end else begin
            pc_sel_s = PC_SEL_SEQ;
        end
    end

    // Next-PC data mux; sequential fetch wraps at 32 bits.
    always_comb begin
        next_pc_s = PC_RESET;
        case (pc_sel_s)
            PC_SEL_RESET:    next_pc_s = PC_RESET;
            PC_SEL_EXC:      next_pc_s = EXC_VECTOR;
            PC_SEL_ERET:     next_pc_s = epc;
            PC_SEL_HOLD:     next_pc_s = pc_r;
            PC_SEL_REDIRECT: next_pc_s = redirect_pc;
            PC_SEL_SEQ:      next_pc_s = pc_r + PC_STEP;
            default:         next_pc_s = PC_RESET;
        endcase
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= PC_RESET;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//  IF stage of the pipelined MIPS core. Holds the PC (fetch_pc_reg),
//  presents it to instruction memory, checks the fetch address for AdEL
//  and loads the IF/ID register. Branches/jumps have one delay slot, so a
//  redirect still loads the instruction currently being fetched.
//  Ports:
//   clk           in   1   clock
//   reset         in   1   synchronous active-high reset
//   stall         in   1   hold PC and IF/ID
//   redirect      in   1   ID resolved taken branch/jump
//   redirect_pc   in   32  redirect target
//   id_is_branch  in   1   instruction in ID is a branch/jump
//   exc_req       in   1   exception/interrupt entry this cycle
//   eret_req      in   1   eret committed this cycle
//   epc           in   32  eret return target
//   imem          if      instruction memory bus (master)
//   pc            out  32  current IF PC
//   id_instr      out  32  IF/ID instruction
//   id_pc         out  32  IF/ID PC
//   id_bd         out  1   IF/ID instruction is in a delay slot
//   id_exccode    out  5   IF/ID pending ExcCode, 0 = none
//   id_valid      out  1   IF/ID holds a real instruction
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    input  logic                  id_is_branch,
    input  logic                  exc_req,
    input  logic                  eret_req,
    input  logic [31:0]           epc,
    fetch_stage_if.master         imem,
    output logic [31:0]           pc,
    output logic [31:0]           id_instr,
    output logic [31:0]           id_pc,
    output logic                  id_bd,
    output logic [4:0]            id_exccode,
    output logic                  id_valid
);

    logic [31:0] pc_s;
    logic        fetch_ok_s;
    ifid_t       ifid_load_s;
    ifid_t       ifid_r;

    fetch_pc_reg u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .epc         (epc),
        .pc          (pc_s)
    );

    assign imem.imem_addr = pc_s;
    assign fetch_ok_s     = fetch_addr_legal(pc_s);

    // Build the IF/ID value for a normal load; an illegal fetch becomes a
    // valid NOP carrying AdEL so the bad PC reaches CP0 in order.
    always_comb begin
        ifid_load_s       = '0;
        ifid_load_s.pc    = pc_s;
        ifid_load_s.bd    = id_is_branch;
        ifid_load_s.valid = 1'b1;
        if (fetch_ok_s) begin
            ifid_load_s.instr   = imem.imem_rdata;
            ifid_load_s.exccode = EXC_NONE;
        end else begin
            ifid_load_s.instr   = NOP_WORD;
            ifid_load_s.exccode = EXC_ADEL;
        end
    end

    // IF/ID register: exception/eret flush beats stall, stall holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_r <= '0;
        end else if (exc_req || eret_req) begin
            ifid_r <= '0;
        end else if (stall) begin
            ifid_r <= ifid_r;
        end else begin
            ifid_r <= ifid_load_s;
        end
    end

    assign pc         = pc_s;
    assign id_instr   = ifid_r.instr;
    assign id_pc      = ifid_r.pc;
    assign id_bd      = ifid_r.bd;
    assign id_exccode = ifid_r.exccode;
    assign id_valid   = ifid_r.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//  Directed scenarios plus a randomized run of the IF stage, checked
//  against a behavioural model of the fetch rules kept in this bench.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_is_branch;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_bd;
    logic [4:0]  id_exccode;
    logic        id_valid;

    int checks;
    int failures;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic        m_bd;
    logic [4:0]  m_exc;
    logic        m_valid;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_is_branch (id_is_branch),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .imem         (bus),
        .pc           (pc),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_bd        (id_bd),
        .id_exccode   (id_exccode),
        .id_valid     (id_valid)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the fetch rules to the model for one edge using current inputs.
    task automatic model_step();
        logic ok;
        if (reset) begin
            m_pc = 32'h0000_3000;
            m_instr = 32'd0; m_idpc = 32'd0; m_bd = 1'b0; m_exc = 5'd0; m_valid = 1'b0;
        end else if (exc_req || eret_req) begin
            m_pc = exc_req ? 32'h0000_4180 : epc;
            m_instr = 32'd0; m_idpc = 32'd0; m_bd = 1'b0; m_exc = 5'd0; m_valid = 1'b0;
        end else if (!stall) begin
            ok = (m_pc % 32'd4 == 32'd0) && (m_pc >= 32'h0000_3000) && (m_pc <= 32'h0000_6FFC);
            m_idpc  = m_pc;
            m_bd    = id_is_branch;
            m_valid = 1'b1;
            m_instr = ok ? mem_word(m_pc) : 32'd0;
            m_exc   = ok ? 5'd0 : 5'd4;
            m_pc    = redirect ? redirect_pc : m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        id_is_branch = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;
    endtask

    task automatic jump_to(input logic [31:0] target);
        clear_inputs();
        redirect = 1'b1; redirect_pc = target;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (pc !== 32'h0000_3000 || bus.imem_addr !== 32'h0000_3000) begin
            failures++; $display("FAIL reset_pc got pc=%h addr=%h want 00003000", pc, bus.imem_addr);
        end
        checks++;
        if ({id_instr, id_pc, id_bd, id_exccode, id_valid} !== 71'd0) begin
            failures++; $display("FAIL reset_ifid got instr=%h pc=%h bd=%b exc=%0d v=%b want all 0",
                                 id_instr, id_pc, id_bd, id_exccode, id_valid);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc !== 32'h0000_3004 + 32'(i) * 32'd4 || id_pc !== 32'h0000_3000 + 32'(i) * 32'd4 ||
                id_valid !== 1'b1 || id_instr !== mem_word(32'h0000_3000 + 32'(i) * 32'd4)) begin
                failures++; $display("FAIL seq_fetch%0d got pc=%h id_pc=%h v=%b instr=%h", i, pc, id_pc, id_valid, id_instr);
            end
        end
    endtask

    task automatic test_redirect();
        clear_inputs();
        id_is_branch = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3100;
        tick();
        checks++;
        if (pc !== 32'h0000_3100 || id_pc !== 32'h0000_3008 || id_bd !== 1'b1 || id_valid !== 1'b1) begin
            failures++; $display("FAIL redirect got pc=%h id_pc=%h bd=%b v=%b want 00003100 00003008 1 1",
                                 pc, id_pc, id_bd, id_valid);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        jump_to(32'h0000_3010);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_5000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'h0000_3010 || id_pc !== 32'h0000_3100 || id_instr !== mem_word(32'h0000_3100) ||
                id_bd !== 1'b0 || id_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d got pc=%h id_pc=%h bd=%b", i, pc, id_pc, id_bd);
            end
        end
        clear_inputs();
        tick();
        checks++;
        if (pc !== 32'h0000_3014 || id_pc !== 32'h0000_3010) begin
            failures++; $display("FAIL stall_release got pc=%h id_pc=%h want 00003014 00003010", pc, id_pc);
        end
    endtask

    task automatic test_exc_eret();
        jump_to(32'h0000_3020);
        stall = 1'b1; exc_req = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0000_4180 || id_valid !== 1'b0 || id_instr !== 32'd0) begin
            failures++; $display("FAIL exc_entry got pc=%h v=%b instr=%h want 00004180 0 0", pc, id_valid, id_instr);
        end
        clear_inputs();
        eret_req = 1'b1; epc = 32'h0000_3024; id_is_branch = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0000_3024 || id_valid !== 1'b0 || id_bd !== 1'b0) begin
            failures++; $display("FAIL eret got pc=%h v=%b bd=%b want 00003024 0 0", pc, id_valid, id_bd);
        end
        clear_inputs();
    endtask

    task automatic test_adel();
        logic [31:0] targets [3];
        logic [4:0]  want_exc [3];
        targets[0] = 32'h0000_3002; want_exc[0] = 5'd4;
        targets[1] = 32'h0000_7000; want_exc[1] = 5'd4;
        targets[2] = 32'h0000_6FFC; want_exc[2] = 5'd0;
        for (int i = 0; i < 3; i++) begin
            jump_to(targets[i]);
            tick();
            checks++;
            if (id_pc !== targets[i] || id_exccode !== want_exc[i] || id_valid !== 1'b1 ||
                id_instr !== ((want_exc[i] == 5'd0) ? mem_word(targets[i]) : 32'd0)) begin
                failures++; $display("FAIL adel%0d got id_pc=%h exc=%0d instr=%h v=%b want pc=%h exc=%0d",
                                     i, id_pc, id_exccode, id_instr, id_valid, targets[i], want_exc[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        clear_inputs();
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_3200;
        tick();
        checks++;
        if (pc !== 32'h0000_4180 || id_valid !== 1'b0) begin
            failures++; $display("FAIL exc_over_eret got pc=%h v=%b want 00004180 0", pc, id_valid);
        end
        clear_inputs();
        tick();
        stall = 1'b1; reset = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0000_3000 || id_valid !== 1'b0 || id_pc !== 32'd0) begin
            failures++; $display("FAIL reset_in_stall got pc=%h v=%b id_pc=%h want 00003000 0 0", pc, id_valid, id_pc);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        clear_inputs();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 400; i++) begin
            clear_inputs();
            reset        = ($urandom_range(0, 99) < 2);
            stall        = ($urandom_range(0, 99) < 20);
            redirect     = ($urandom_range(0, 99) < 20);
            id_is_branch = redirect | ($urandom_range(0, 99) < 10);
            exc_req      = ($urandom_range(0, 99) < 4);
            eret_req     = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 9) < 7)
                redirect_pc = 32'h0000_3000 + {18'd0, $urandom_range(0, 4095), 2'b00};
            else
                redirect_pc = $urandom;
            if ($urandom_range(0, 1) == 0)
                epc = 32'h0000_3000 + {18'd0, $urandom_range(0, 4095), 2'b00};
            else
                epc = $urandom;
            tick();
            checks++;
            if (pc !== m_pc || bus.imem_addr !== m_pc) begin
                failures++; $display("FAIL rand_pc[%0d] got pc=%h addr=%h want %h", i, pc, bus.imem_addr, m_pc);
            end
            checks++;
            if (id_instr !== m_instr || id_pc !== m_idpc) begin
                failures++; $display("FAIL rand_ifid[%0d] got instr=%h pc=%h want %h %h", i, id_instr, id_pc, m_instr, m_idpc);
            end
            checks++;
            if (id_bd !== m_bd || id_exccode !== m_exc || id_valid !== m_valid) begin
                failures++; $display("FAIL rand_flags[%0d] got bd=%b exc=%0d v=%b want %b %0d %b",
                                     i, id_bd, id_exccode, id_valid, m_bd, m_exc, m_valid);
            end
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        reset = 1'b1;
        m_pc = 32'd0; m_instr = 32'd0; m_idpc = 32'd0; m_bd = 1'b0; m_exc = 5'd0; m_valid = 1'b0;
        #1;
        test_reset();
        test_redirect();
        test_stall();
        test_exc_eret();
        test_adel();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
